// File: rtl/ysyx_040066_lsu.sv
// Load/store unit: one outstanding request, 64-bit bus, lane extract/extend,
// misalignment trap, flush suppression.
module ysyx_040066_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_memop,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        bus_valid,
    output logic        bus_we,
    input  logic        bus_ready,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wmask,
    input  logic        bus_rvalid,
    input  logic [63:0] bus_rdata,
    input  logic        bus_err,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [1:0]  resp_err,
    input  logic        flush
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [63:0] a_addr;
    logic [63:0] a_wdata;
    logic [2:0]  a_memop;
    logic [7:0]  a_wmask;
    logic        a_we;
    logic        sup;
    logic        mis;
    logic        accept;
    logic        sx;
    logic [63:0] lane;
    logic [63:0] ld_data;
    logic        unused_rd;

    // a request with req_wr low is a load; req_rd carries no extra meaning
    assign unused_rd = req_rd;

    assign req_ready = (state == IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign bus_valid = (state == CMD);
    assign bus_we    = a_we;
    assign bus_addr  = {a_addr[63:3], 3'b000};
    assign bus_wdata = a_wdata;
    assign bus_wmask = a_we ? a_wmask : 8'h00;
    assign resp_valid = (state == RESP);

    always_comb begin
        mis = 1'b0;
        case (req_memop[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = req_addr[0];
            2'b10:   mis = |req_addr[1:0];
            default: mis = |req_addr[2:0];
        endcase
    end

    always_comb begin
        sx      = !a_memop[2];
        lane    = bus_rdata >> {a_addr[2:0], 3'b000};
        ld_data = lane;
        case (a_memop[1:0])
            2'b00:   ld_data = {{56{sx & lane[7]}}, lane[7:0]};
            2'b01:   ld_data = {{48{sx & lane[15]}}, lane[15:0]};
            2'b10:   ld_data = {{32{sx & lane[31]}}, lane[31:0]};
            default: ld_data = lane;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_n = mis ? RESP : CMD;
            end
            CMD: begin
                // once the bus has taken the command it must be seen through
                if (bus_ready)
                    state_n = WAIT;
                else if (flush)
                    state_n = IDLE;
            end
            WAIT: begin
                if (bus_rvalid)
                    state_n = (sup || flush) ? IDLE : RESP;
            end
            RESP: begin
                if (flush || resp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sup       <= 1'b0;
            resp_data <= 64'h0;
            resp_err  <= 2'b00;
            a_addr    <= 64'h0;
            a_wdata   <= 64'h0;
            a_memop   <= 3'b000;
            a_wmask   <= 8'h00;
            a_we      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_addr  <= req_addr;
                a_wdata <= req_wdata;
                a_memop <= req_memop;
                a_wmask <= req_wmask;
                a_we    <= req_wr;
                sup     <= 1'b0;
                if (mis) begin
                    resp_data <= 64'h0;
                    resp_err  <= 2'b01;
                end
            end
            if ((state == CMD) && bus_ready && flush)
                sup <= 1'b1;
            if ((state == WAIT) && flush)
                sup <= 1'b1;
            if ((state == WAIT) && bus_rvalid) begin
                resp_data <= (a_we || bus_err) ? 64'h0 : ld_data;
                resp_err  <= bus_err ? 2'b10 : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_040066_lsu.sv
// Bench for ysyx_040066_lsu: byte-level memory model, bus responder,
// bus and response scoreboards, directed corner cases then random traffic.
module tb_ysyx_040066_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_rd, req_wr;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_memop;
    logic [7:0]  req_wmask;
    logic        bus_valid, bus_we, bus_ready;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_rvalid, bus_err;
    logic [63:0] bus_rdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_data;
    logic [1:0]  resp_err;
    logic        flush;

    always #5 clk = ~clk;

    ysyx_040066_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_memop(req_memop),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .flush(flush)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  err;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  wmask;
        logic [63:0] wdata;
    } cmd_t;

    resp_t resp_q[$];
    cmd_t  bus_q[$];

    logic [7:0]  ref_mem[bit [63:0]];
    logic [63:0] bus_mem[bit [63:0]];

    int hold_bus_ready = 0;
    int hold_resp_ready = 0;
    bit bus_ready_always = 0;
    bit resp_ready_always = 0;
    int rv_delay_force = -1;
    int cmd_count = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(bit [63:0] a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] ref_rd(bit [63:0] a);
        if (ref_mem.exists(a))
            return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [63:0] bus_rd(bit [63:0] wa);
        logic [63:0] w;
        if (bus_mem.exists(wa))
            return bus_mem[wa];
        for (int i = 0; i < 8; i++)
            w[8*i +: 8] = init_byte(wa + 64'(i));
        return w;
    endfunction

    task automatic set_word(input bit [63:0] wa, input logic [63:0] w);
        bus_mem[wa] = w;
        for (int i = 0; i < 8; i++)
            ref_mem[wa + 64'(i)] = w[8*i +: 8];
    endtask

    // Reference: access size from memop, byte-wise memory, fault when addr bit 12 set
    task automatic issue(input bit wr, input logic [2:0] op,
                         input logic [63:0] addr, input logic [63:0] v,
                         input bit exp_resp, input bit exp_cmd);
        int          n;
        bit          mis;
        bit          fault;
        logic [63:0] wd;
        logic [7:0]  wm;
        logic [63:0] ld;
        resp_t       r;
        cmd_t        c;
        int          t;
        n     = 1 << op[1:0];
        mis   = (addr & 64'(n - 1)) != 0;
        fault = addr[12];
        for (int i = 0; i < 8; i++)
            wd[8*i +: 8] = v[8*(i % n) +: 8];
        wm = 8'(((1 << n) - 1) << addr[2:0]);
        @(negedge clk);
        req_valid = 1'b1;
        req_rd    = !wr;
        req_wr    = wr;
        req_addr  = addr;
        req_memop = op;
        req_wdata = wd;
        req_wmask = wm;
        t = 0;
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed %b want 1", req_ready);
        end
        if (mis) begin
            r.data = 64'h0;
            r.err  = 2'b01;
        end else begin
            if (exp_cmd) begin
                c.addr  = addr & ~64'h7;
                c.we    = wr;
                c.wmask = wr ? wm : 8'h00;
                c.wdata = wd;
                bus_q.push_back(c);
            end
            if (wr) begin
                if (!fault)
                    for (int i = 0; i < n; i++)
                        ref_mem[addr + 64'(i)] = v[8*i +: 8];
                r.data = 64'h0;
                r.err  = fault ? 2'b10 : 2'b00;
            end else begin
                ld = 64'h0;
                for (int i = 0; i < n; i++)
                    ld[8*i +: 8] = ref_rd(addr + 64'(i));
                if (n < 8 && !op[2] && ld[8*n-1])
                    ld = ld | (~64'h0 << (8 * n));
                r.data = fault ? 64'h0 : ld;
                r.err  = fault ? 2'b10 : 2'b00;
            end
        end
        if (exp_resp)
            resp_q.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (resp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(resp_q.size()), 64'h0);
    endtask

    // Bus responder and command scoreboard
    initial begin
        bit          hs;
        bit          pend;
        bit          prev_stall;
        bit          err_n;
        int          dly;
        logic [63:0] rdata_n;
        logic [63:0] p_addr, p_wdata, h_addr, h_wdata, w;
        logic [7:0]  p_wmask, h_wmask;
        logic        p_we, h_we;
        cmd_t        c;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 64'h0;
        bus_err    = 1'b0;
        pend       = 0;
        prev_stall = 0;
        dly        = 0;
        forever begin
            @(negedge clk);
            hs      = bus_valid && bus_ready && rst;
            h_addr  = bus_addr;
            h_we    = bus_we;
            h_wmask = bus_wmask;
            h_wdata = bus_wdata;
            if (prev_stall && bus_valid && rst) begin
                chk("bus_addr_stable", bus_addr, p_addr);
                chk("bus_wmask_stable", 64'(bus_wmask), 64'(p_wmask));
                chk("bus_we_stable", 64'(bus_we), 64'(p_we));
                if (p_we)
                    chk("bus_wdata_stable", bus_wdata, p_wdata);
            end
            prev_stall = bus_valid && !bus_ready && rst;
            p_addr  = bus_addr;
            p_we    = bus_we;
            p_wmask = bus_wmask;
            p_wdata = bus_wdata;
            if (hs) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus_cmd: addr %h we %b", h_addr, h_we);
                end else begin
                    c = bus_q.pop_front();
                    chk("bus_addr", h_addr, c.addr);
                    chk("bus_we", 64'(h_we), 64'(c.we));
                    chk("bus_wmask", 64'(h_wmask), 64'(c.wmask));
                    if (c.we)
                        chk("bus_wdata", h_wdata, c.wdata);
                end
            end
            @(posedge clk);
            #1;
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            bus_rdata  = {$urandom, $urandom};
            if (hs) begin
                cmd_count++;
                err_n = h_addr[12];
                if (h_we && !err_n) begin
                    w = bus_rd(h_addr);
                    for (int i = 0; i < 8; i++)
                        if (h_wmask[i])
                            w[8*i +: 8] = h_wdata[8*i +: 8];
                    bus_mem[h_addr] = w;
                end
                rdata_n = h_we ? {$urandom, $urandom} : bus_rd(h_addr);
                dly  = (rv_delay_force >= 0) ? rv_delay_force : int'($urandom_range(0, 3));
                pend = 1;
            end
            if (pend) begin
                if (dly == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata_n;
                    bus_err    = err_n;
                    pend = 0;
                end else begin
                    dly--;
                end
            end
            if (hold_bus_ready > 0) begin
                bus_ready = 1'b0;
                hold_bus_ready--;
            end else begin
                bus_ready = bus_ready_always || ($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_resp_ready > 0) begin
                resp_ready = 1'b0;
                hold_resp_ready--;
            end else begin
                resp_ready = resp_ready_always || ($urandom_range(0, 1) != 0);
            end
        end
    end

    // Response monitor; a response shown while flush is high is being discarded
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst && resp_valid && !flush) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: data %h err %b", resp_data, resp_err);
                end else begin
                    r = resp_q[0];
                    chk("resp_data", resp_data, r.data);
                    chk("resp_err", 64'(resp_err), 64'(r.err));
                    if (resp_ready)
                        void'(resp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int c0;
        int t;
        bit seen;
        bit wr;
        logic [2:0]  op;
        logic [63:0] a;
        rst = 1'b0;
        flush = 1'b0;
        req_valid = 1'b0;
        req_rd = 1'b0;
        req_wr = 1'b0;
        req_addr = 64'h0;
        req_memop = 3'b000;
        req_wdata = 64'h0;
        req_wmask = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_bus_valid", 64'(bus_valid), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_err", 64'(resp_err), 64'h0);
        chk("rst_resp_data", resp_data, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'h1);

        // signed and unsigned byte loads, minimum latency
        set_word(64'h8000_0000, 64'h0000_0000_8000_0000);
        bus_ready_always  = 1;
        resp_ready_always = 1;
        rv_delay_force    = 0;
        issue(0, 3'b000, 64'h8000_0003, 64'h0, 1, 1);
        @(negedge clk);
        chk("lat_c1", 64'(resp_valid), 64'h0);
        @(negedge clk);
        chk("lat_c2", 64'(resp_valid), 64'h0);
        @(negedge clk);
        chk("lat_c3", 64'(resp_valid), 64'h1);
        chk("lb_value", resp_data, 64'hFFFF_FFFF_FFFF_FF80);
        issue(0, 3'b100, 64'h8000_0003, 64'h0, 1, 1);
        wait_drain("drain_lb");

        // word store into the upper half
        issue(1, 3'b010, 64'h8000_0004, 64'h1234_5678, 1, 1);
        wait_drain("drain_sw");

        // misaligned word: no bus, response next cycle
        resp_ready_always = 0;
        hold_resp_ready = 2;
        issue(0, 3'b010, 64'h8000_0002, 64'h0, 1, 1);
        @(negedge clk);
        chk("mis_resp_valid", 64'(resp_valid), 64'h1);
        chk("mis_bus_valid", 64'(bus_valid), 64'h0);
        resp_ready_always = 1;
        wait_drain("drain_mis");

        // stalled bus and stalled writeback
        bus_ready_always = 0;
        hold_bus_ready = 5;
        resp_ready_always = 0;
        hold_resp_ready = 1000;
        rv_delay_force = -1;
        c0 = cmd_count;
        issue(0, 3'b011, 64'h8000_0008, 64'h0, 1, 1);
        t = 0;
        while (!resp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("stall_resp_seen", 64'(resp_valid), 64'h1);
        hold_resp_ready = 3;
        wait_drain("drain_stall");
        chk("stall_one_cmd", 64'(cmd_count - c0), 64'h1);

        // flush while command waits for the bus
        hold_bus_ready = 10;
        resp_ready_always = 1;
        issue(0, 3'b011, 64'h8000_0010, 64'h0, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("fcmd_bus_valid_before", 64'(bus_valid), 64'h1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fcmd_bus_valid_after", 64'(bus_valid), 64'h0);
        chk("fcmd_req_ready", 64'(req_ready), 64'h1);
        hold_bus_ready = 0;

        // flush while response is presented
        resp_ready_always = 0;
        hold_resp_ready = 5;
        issue(0, 3'b010, 64'h8000_0001, 64'h0, 0, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fresp_valid", 64'(resp_valid), 64'h0);
        resp_ready_always = 1;

        // flush in WAIT, then a half-word load
        set_word(64'h8000_0010, 64'hBEEF_0000_0000_0000);
        bus_ready_always = 1;
        rv_delay_force = 3;
        issue(0, 3'b011, 64'h8000_0018, 64'h0, 0, 1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (8) @(negedge clk);
        rv_delay_force = 0;
        issue(0, 3'b001, 64'h8000_0016, 64'h0, 1, 1);
        t = 0;
        while (!resp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("lh_value", resp_data, 64'hFFFF_FFFF_FFFF_BEEF);
        wait_drain("drain_lh");

        // flush in IDLE blocks acceptance
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fidle_req_ready", 64'(req_ready), 64'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fidle_req_ready_after", 64'(req_ready), 64'h1);

        // reset in WAIT, late completion ignored
        rv_delay_force = 4;
        issue(0, 3'b011, 64'h8000_0020, 64'h0, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("wrst_bus_valid", 64'(bus_valid), 64'h0);
        chk("wrst_resp_valid", 64'(resp_valid), 64'h0);
        chk("wrst_resp_err", 64'(resp_err), 64'h0);
        chk("wrst_resp_data", resp_data, 64'h0);
        chk("wrst_req_ready", 64'(req_ready), 64'h1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid)
                seen = 1;
        end
        chk("wrst_no_resp", 64'(seen), 64'h0);

        // random traffic
        bus_ready_always = 0;
        resp_ready_always = 0;
        rv_delay_force = -1;
        for (int k = 0; k < 200; k++) begin
            wr = ($urandom_range(0, 2) == 0);
            op = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            a  = 64'h8000_0000 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0)
                a[12] = 1'b1;
            issue(wr, op, a, {$urandom, $urandom}, 1, 1);
        end
        wait_drain("drain_random");
        chk("bus_q_empty", 64'(bus_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_040066_lsu.md
YSYX_040066_LSU -- requirements
Module: ysyx_040066_lsu

Interface
REQ-001 clk  in  1  clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-low; clock clk.
REQ-003 req_valid  in  1  pipeline memory request present.
REQ-004 req_ready  out  1  LSU accepts request this cycle.
REQ-005 req_rd, req_wr  in  1 each  load / store request (both high is illegal; treat as store).
REQ-006 req_addr  in  64  byte address (ALU result).
REQ-007 req_memop  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D; bit2 set = unsigned load.
REQ-008 req_wdata, req_wmask  in  64, 8  store data pre-replicated per lane, byte mask.
REQ-009 bus_valid, bus_we  out  1 each  bus command valid, write enable.
REQ-010 bus_ready  in  1  bus accepts command.
REQ-011 bus_addr, bus_wdata, bus_wmask  out  64, 64, 8  addr with [2:0]=0, write data, write mask.
REQ-012 bus_rvalid, bus_rdata, bus_err  in  1, 64, 1  read/write completion, read data, access fault.
REQ-013 resp_valid, resp_ready  out, in  1 each  result handshake to writeback.
REQ-014 resp_data, resp_err  out  64, 2  loaded/extended data; err 01 misaligned, 10 bus fault.
REQ-015 flush  in  1  discard current request's response.

Function
REQ-016 FSM states IDLE, CMD, WAIT, RESP; req_ready=1 only in IDLE.
REQ-017 Accept (req_valid&&req_ready) latches addr, memop, wdata, wmask, type; IDLE->CMD.
REQ-018 Misaligned (H: addr[0]; W: addr[1:0]!=0; D: addr[2:0]!=0) skips bus: IDLE->RESP, resp_err=01, resp_data=0.
REQ-019 CMD: bus_valid=1, fields stable until bus_ready; bus_valid&&bus_ready -> WAIT; bus_wmask=0 and bus_we=0 for loads.
REQ-020 WAIT: bus_rvalid -> RESP; rdata/bus_err captured same edge; bus_rvalid in CMD/IDLE ignored.
REQ-021 Load extract: lane = rdata >> (8*addr[2:0]) (H uses addr[2:1], W addr[2]); sign-extend to 64 unless memop[2].
REQ-022 Store: resp_data=0; resp_err=10 if bus_err else 00.
REQ-023 RESP: resp_valid=1, outputs stable until resp_ready; handshake -> IDLE.
REQ-024 Minimum latency accept->resp_valid: 3 cycles (bus_ready and bus_rvalid each 1 cycle after asserted state); back-to-back request accepted the cycle after resp handshake.
REQ-025 flush in CMD before bus handshake: bus_valid drops next cycle, -> IDLE, no response.
REQ-026 flush in CMD with simultaneous bus_ready, or in WAIT: command completes on bus, response suppressed, -> IDLE after bus_rvalid.
REQ-027 flush in RESP: resp_valid drops next cycle, -> IDLE; flush in IDLE: no effect, req still acceptable that cycle? No: req_ready forced 0 while flush=1.
REQ-028 busy out not provided; req_ready low is the sole backpressure.

Reset
REQ-029 rst=0 at posedge: state IDLE, bus_valid=0, resp_valid=0, resp_err=00, resp_data=0, suppress flag cleared, regardless of state (mid-transaction abandoned; a late bus_rvalid after reset is ignored).
REQ-030 req_ready=1 on first cycle after rst rises.

Verification
REQ-031 LB addr 0x8000_0003, rdata 0x0000_0000_8000_0000 shifted lane = 0x80 -> resp_data 0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
REQ-032 SW addr 0x8000_0004, wdata 0x1234_5678_1234_5678, wmask 0xF0 -> bus_addr 0x8000_0000, bus_we=1, bus_wmask 0xF0; resp_data 0, resp_err 00.
REQ-033 LW addr 0x8000_0002 -> no bus_valid ever, resp_valid on next cycle with resp_err 01.
REQ-034 LD with bus_ready held 0 for 5 cycles, resp_ready held 0 for 3 -> bus fields stable throughout; resp_data stable; exactly one bus command.
REQ-035 flush in WAIT of LD -> no resp_valid; next LH addr 0x...6, rdata 0xBEEF_0000_0000_0000 -> 0xFFFF_FFFF_FFFF_BEEF.
REQ-036 rst=0 in WAIT, then bus_rvalid -> no resp_valid; outputs at reset values.
